// File: rtl/piso_shift_tx.sv
// Parallel-in, serial-out transmitter: takes a WIDTH-bit word over valid/ready
// and shifts it onto sout one bit per clock, back-to-back frames without gaps.
module piso_shift_tx #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din_valid,
  input  logic [WIDTH-1:0] din,
  output logic             din_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             frame_start,
  output logic             frame_last
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state, state_d;
  logic [CNT_W-1:0] bit_cnt, bit_cnt_d;
  logic [WIDTH-1:0] shift_reg, shift_reg_d;
  logic             sout_d, sout_valid_d, frame_start_d, frame_last_d;
  logic             last_bit;
  logic             accept;

  // Ready in idle or while the last bit of the current frame is on the line
  assign last_bit  = (state == SHIFT) && (bit_cnt == LAST_IDX);
  assign din_ready = rst_n & ((state == IDLE) | last_bit);
  assign accept    = din_valid & din_ready;

  // Next-state, next-shift and next-output logic
  always_comb begin
    state_d       = state;
    bit_cnt_d     = bit_cnt;
    shift_reg_d   = shift_reg;
    sout_d        = 1'b0;
    sout_valid_d  = 1'b0;
    frame_start_d = 1'b0;
    frame_last_d  = 1'b0;

    if (accept) begin
      // New word: its first bit goes out on the very next cycle
      state_d       = SHIFT;
      bit_cnt_d     = '0;
      shift_reg_d   = din;
      sout_d        = MSB_FIRST ? din[WIDTH-1] : din[0];
      sout_valid_d  = 1'b1;
      frame_start_d = 1'b1;
    end else if (state == SHIFT) begin
      if (!last_bit) begin
        bit_cnt_d    = bit_cnt + CNT_W'(1);
        sout_valid_d = 1'b1;
        frame_last_d = (bit_cnt_d == LAST_IDX);
        if (MSB_FIRST) begin
          shift_reg_d = {shift_reg[WIDTH-2:0], 1'b0};
          sout_d      = shift_reg[WIDTH-2];
        end else begin
          shift_reg_d = {1'b0, shift_reg[WIDTH-1:1]};
          sout_d      = shift_reg[1];
        end
      end else begin
        // Frame done with nothing queued behind it
        state_d   = IDLE;
        bit_cnt_d = '0;
      end
    end
  end

  // State and registered outputs, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      shift_reg   <= '0;
      sout        <= 1'b0;
      sout_valid  <= 1'b0;
      frame_start <= 1'b0;
      frame_last  <= 1'b0;
    end else begin
      state       <= state_d;
      bit_cnt     <= bit_cnt_d;
      shift_reg   <= shift_reg_d;
      sout        <= sout_d;
      sout_valid  <= sout_valid_d;
      frame_start <= frame_start_d;
      frame_last  <= frame_last_d;
    end
  end

endmodule

// File: tb/tb_piso_shift_tx.sv
// Directed bench for piso_shift_tx: MSB-first and LSB-first instances.
module tb_piso_shift_tx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       din_valid, din_valid2;
  logic [7:0] din, din2;
  logic       din_ready, sout, sout_valid, frame_start, frame_last;
  logic       din_ready2, sout2, sout_valid2, frame_start2, frame_last2;

  int checks   = 0;
  int failures = 0;

  piso_shift_tx #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .rst_n(rst_n), .din_valid(din_valid), .din(din),
    .din_ready(din_ready), .sout(sout), .sout_valid(sout_valid),
    .frame_start(frame_start), .frame_last(frame_last)
  );

  piso_shift_tx #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .din_valid(din_valid2), .din(din2),
    .din_ready(din_ready2), .sout(sout2), .sout_valid(sout_valid2),
    .frame_start(frame_start2), .frame_last(frame_last2)
  );

  always #5 clk = ~clk;

  // Advance one clock and settle just after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; din_valid = 1'b1; din = 8'hA5; din_valid2 = 1'b1; din2 = 8'h5A;
    #1;
    checks++;
    if (din_ready !== 1'b0) begin
      failures++; $display("FAIL reset_ready_pre got=%b exp=0", din_ready);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({din_ready, sout, sout_valid, frame_start, frame_last} !== 5'b0 ||
          {din_ready2, sout2, sout_valid2, frame_start2, frame_last2} !== 5'b0) begin
        failures++;
        $display("FAIL reset_outputs cyc=%0d got=%b/%b exp=00000", i,
                 {din_ready, sout, sout_valid, frame_start, frame_last},
                 {din_ready2, sout2, sout_valid2, frame_start2, frame_last2});
      end
    end
    din_valid = 1'b0; din_valid2 = 1'b0;
    rst_n = 1'b1;
    tick();
    checks++;
    if (din_ready !== 1'b1 || din_ready2 !== 1'b1 || sout_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_release got ready=%b ready2=%b sv=%b exp 1 1 0",
               din_ready, din_ready2, sout_valid);
    end
  endtask

  // Accept one word on the MSB-first instance and check the 8 bits plus trailing idle
  task automatic test_msb_frame(input logic [7:0] word, input logic [7:0] exp_bits, input string tag);
    din = word; din_valid = 1'b1;
    tick();
    din_valid = 1'b0; din = 8'h00;
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (sout !== exp_bits[7-k] || sout_valid !== 1'b1 ||
          frame_start !== (k == 0) || frame_last !== (k == 7)) begin
        failures++;
        $display("FAIL %s bit%0d got s=%b v=%b fs=%b fl=%b exp s=%b v=1 fs=%b fl=%b",
                 tag, k, sout, sout_valid, frame_start, frame_last,
                 exp_bits[7-k], (k == 0), (k == 7));
      end
      tick();
    end
    checks++;
    if (sout_valid !== 1'b0 || sout !== 1'b0 || frame_start !== 1'b0 || frame_last !== 1'b0) begin
      failures++;
      $display("FAIL %s idle_after got s=%b v=%b exp 0 0", tag, sout, sout_valid);
    end
  endtask

  task automatic test_lsb_frame(input logic [7:0] word, input logic [7:0] exp_bits, input string tag);
    din2 = word; din_valid2 = 1'b1;
    tick();
    din_valid2 = 1'b0; din2 = 8'hFF;
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (sout2 !== exp_bits[7-k] || sout_valid2 !== 1'b1 ||
          frame_start2 !== (k == 0) || frame_last2 !== (k == 7)) begin
        failures++;
        $display("FAIL %s bit%0d got s=%b v=%b fs=%b fl=%b exp s=%b",
                 tag, k, sout2, sout_valid2, frame_start2, frame_last2, exp_bits[7-k]);
      end
      tick();
    end
    checks++;
    if (sout_valid2 !== 1'b0 || sout2 !== 1'b0) begin
      failures++;
      $display("FAIL %s idle_after got s=%b v=%b exp 0 0", tag, sout2, sout_valid2);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_stream;
    exp_stream = 16'b10100101_00111100;
    din = 8'hA5; din_valid = 1'b1;
    tick();
    din = 8'h3C;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (sout !== exp_stream[15-i] || sout_valid !== 1'b1 ||
          frame_start !== (i == 0 || i == 8) || frame_last !== (i == 7 || i == 15) ||
          din_ready !== (i == 7 || i == 15)) begin
        failures++;
        $display("FAIL b2b bit%0d got s=%b v=%b fs=%b fl=%b rdy=%b exp s=%b rdy=%b",
                 i, sout, sout_valid, frame_start, frame_last, din_ready,
                 exp_stream[15-i], (i == 7 || i == 15));
      end
      if (i == 15) din_valid = 1'b0;
      tick();
    end
    checks++;
    if (sout_valid !== 1'b0 || sout !== 1'b0) begin
      failures++;
      $display("FAIL b2b idle_after got s=%b v=%b exp 0 0", sout, sout_valid);
    end
  endtask

  task automatic test_reset_mid_frame();
    din = 8'hFF; din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    tick(); tick(); tick();
    checks++;
    if (sout !== 1'b1 || sout_valid !== 1'b1 || din_ready !== 1'b0) begin
      failures++;
      $display("FAIL midrst_bit4 got s=%b v=%b rdy=%b exp 1 1 0", sout, sout_valid, din_ready);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (din_ready !== 1'b0) begin
      failures++; $display("FAIL midrst_ready_gated got=%b exp=0", din_ready);
    end
    tick();
    checks++;
    if ({din_ready, sout, sout_valid, frame_start, frame_last} !== 5'b0) begin
      failures++;
      $display("FAIL midrst_outputs got=%b exp=00000",
               {din_ready, sout, sout_valid, frame_start, frame_last});
    end
    rst_n = 1'b1;
    tick();
    test_msb_frame(8'h0F, 8'b00001111, "midrst_0F");
  endtask

  task automatic test_loopback();
    logic [7:0] q[$];
    logic [7:0] cap, word, exp_w;
    logic       pending;
    int         sent, rcvd, cyc;
    cap = '0; pending = 1'b0; sent = 0; rcvd = 0; cyc = 0; word = '0;
    while (rcvd < 100 && cyc < 5000) begin
      if (sout_valid === 1'b1) begin
        cap = {cap[6:0], sout};
        if (frame_last === 1'b1) begin
          exp_w = (q.size() > 0) ? q.pop_front() : 8'hxx;
          checks++;
          if (cap !== exp_w) begin
            failures++;
            $display("FAIL loopback word%0d got=%h exp=%h", rcvd, cap, exp_w);
          end
          rcvd++;
        end
      end
      if (!pending && sent < 100 && $urandom_range(0, 3) != 0) begin
        pending = 1'b1;
        word    = 8'($urandom);
      end
      din_valid = pending;
      din       = pending ? word : 8'($urandom);
      if (pending && din_ready === 1'b1) begin
        q.push_back(word);
        pending = 1'b0;
        sent++;
      end
      tick();
      cyc++;
    end
    din_valid = 1'b0;
    checks++;
    if (rcvd != 100 || q.size() != 0) begin
      failures++;
      $display("FAIL loopback_count got rcvd=%0d left=%0d exp rcvd=100 left=0", rcvd, q.size());
    end
  endtask

  initial begin
    test_reset();
    test_msb_frame(8'hA5, 8'b10100101, "msb_A5");
    test_back_to_back();
    test_lsb_frame(8'h01, 8'b10000000, "lsb_01");
    test_lsb_frame(8'h80, 8'b00000001, "lsb_80");
    test_reset_mid_frame();
    test_loopback();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
